// File: rtl/truth_table_checker_pkg.sv
// ---------------------------------------------------------------------------
// tt_chk_pkg
// Shared definitions for the truth-table checker slice.
//   tt_state_e : sweep sequencer states (IDLE, SETTLE, SAMPLE, DONE)
//   tbl_width  : bit width of a packed expected-response table holding one
//                N_OUT-bit entry for every one of the 2**N_IN input vectors
// ---------------------------------------------------------------------------
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  // Width of the expected table, usable in parameter declarations.
  function automatic int tbl_width(input int n_in, input int n_out);
    return (2 ** n_in) * n_out;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// ---------------------------------------------------------------------------
// tt_settle_timer
// Load/decrement counter that measures how long a stimulus vector is held
// before the response is sampled.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   load   in  reload the counter with SETTLE_CYC-1 (has priority over dec)
//   dec    in  decrement the counter, stopping at zero
//   zero   out counter currently equals zero
// ---------------------------------------------------------------------------
module tt_settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // The counter is reloaded for every new vector and then counts down while
  // the sequencer settles; it saturates at zero so a stray dec is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE_CYC - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
// Self-sequencing response checker for a small combinational block. Walks
// every input vector 0 .. 2**N_IN-1, holds each for SETTLE_CYC+1 cycles,
// samples the block's response and compares it with EXP_TABLE.
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset (aborts a sweep)
//   start          in   request a sweep; honoured only in IDLE or DONE
//   dut_in         out  registered stimulus vector (equals current index)
//   dut_out        in   response of the block under test
//   busy           out  sweep in progress
//   done           out  sweep finished; held until the next accepted start
//   pass           out  valid with done; no vector mismatched
//   err_count      out  number of mismatching vectors in the last sweep
//   fail_valid     out  at least one mismatch seen in this sweep
//   first_fail_idx out  index of the first mismatching vector
// ---------------------------------------------------------------------------
module truth_table_checker
  import tt_chk_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 2,
  parameter int SETTLE_CYC = 2,
  parameter logic [tbl_width(N_IN, N_OUT)-1:0] EXP_TABLE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  tt_state_e        state_q;
  tt_state_e        state_d;
  logic [N_IN-1:0]  idx_q;
  logic             start_ok;
  logic             last_vec;
  logic             mismatch;
  logic             timer_load;
  logic             timer_dec;
  logic             cnt_zero;
  logic [N_OUT-1:0] exp_out;

  // A new start is only honoured when no sweep is running.
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  // The index never wraps; the sweep ends after comparing the all-ones vector.
  assign last_vec = (idx_q == IDX_LAST);
  assign exp_out  = EXP_TABLE[int'(idx_q) * N_OUT +: N_OUT];
  assign mismatch = (dut_out != exp_out);

  // Reload the settle time whenever a fresh vector appears on dut_in.
  assign timer_load = start_ok || ((state_q == SAMPLE) && !last_vec);
  assign timer_dec  = (state_q == SETTLE);

  // The stimulus register is the vector index itself.
  assign dut_in = idx_q;

  tt_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .dec  (timer_dec),
    .zero (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer: settle for the programmed time, sample once, then either
  // move to the next vector or finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SETTLE;
      SETTLE:  if (cnt_zero) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : SETTLE;
      DONE:    if (start_ok) state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  // Index and statistics. A start wipes the previous results; each SAMPLE
  // cycle scores one vector. pass folds in the final vector's own result
  // because err_count only updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (start_ok) begin
      idx_q          <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (state_q == SAMPLE) begin
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid     <= 1'b1;
          first_fail_idx <= idx_q;
        end
      end
      if (last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0) && !mismatch;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// ---------------------------------------------------------------------------
// tb_truth_table_checker
// Drives two checkers (SETTLE_CYC=2 and SETTLE_CYC=1) against a behavioural
// 4-in/2-out block Y=(A&B)|(C&D), Z=A^B^C^D with injectable faults.
// ---------------------------------------------------------------------------
module tb_truth_table_checker;

  // Reference logic block: idx = {A,B,C,D}, result = {Y,Z}.
  function automatic logic [1:0] good_out(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return {(a & b) | (c & d), a ^ b ^ c ^ d};
  endfunction

  function automatic logic [31:0] build_table();
    logic [31:0] t;
    t = '0;
    for (int v = 0; v < 16; v++) t[v*2 +: 2] = good_out(4'(v));
    return t;
  endfunction

  localparam logic [31:0] EXP = build_table();

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] dut_in_a, dut_in_b;
  logic [1:0] dut_out_a, dut_out_b;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [4:0] err_count_a, err_count_b;
  logic [3:0] first_fail_idx_a, first_fail_idx_b;

  logic [1:0] flip [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb dut_out_a = good_out(dut_in_a) ^ flip[dut_in_a];
  always_comb dut_out_b = good_out(dut_in_b);

  truth_table_checker #(
    .N_IN(4), .N_OUT(2), .SETTLE_CYC(2), .EXP_TABLE(EXP)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .fail_valid(fail_valid_a),
    .first_fail_idx(first_fail_idx_a)
  );

  truth_table_checker #(
    .N_IN(4), .N_OUT(2), .SETTLE_CYC(1), .EXP_TABLE(EXP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .fail_valid(fail_valid_b),
    .first_fail_idx(first_fail_idx_b)
  );

  // Observation mux so one set of tasks can drive either checker.
  logic       sel = 1'b0;
  logic [3:0] obs_dut_in, obs_ffi;
  logic       obs_busy, obs_done, obs_pass, obs_fv;
  logic [4:0] obs_err;

  always_comb begin
    obs_dut_in = sel ? dut_in_b         : dut_in_a;
    obs_ffi    = sel ? first_fail_idx_b : first_fail_idx_a;
    obs_busy   = sel ? busy_b           : busy_a;
    obs_done   = sel ? done_b           : done_a;
    obs_pass   = sel ? pass_b           : pass_a;
    obs_fv     = sel ? fail_valid_b     : fail_valid_a;
    obs_err    = sel ? err_count_b      : err_count_a;
  end

  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    int    exp_fv;
    int    exp_first;
    int    exp_pass;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Fault modes for the block driven by checker A.
  task automatic setFault(input int mode);
    for (int v = 0; v < 16; v++) begin
      logic [1:0] g;
      g = good_out(4'(v));
      case (mode)
        1:       flip[v] = {1'b0, g[0]};          // Z stuck-at-0
        2:       flip[v] = {~g[1], 1'b0};         // Y stuck-at-1
        3:       flip[v] = {g[1], 1'b0};          // Y stuck-at-0
        4:       flip[v] = 2'b11;                 // both outputs inverted
        5:       flip[v] = (v == 15) ? 2'b01 : 2'b00;
        default: flip[v] = 2'b00;
      endcase
    end
  endtask

  task automatic setStart(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Pulse start, then follow the sweep cycle by cycle until done, checking
  // that dut_in advances every sc+1 cycles and busy stays high meanwhile.
  // restart_at >= 0 re-pulses start at that cycle of the sweep.
  task automatic applyStimulus(input int sc, input int restart_at,
                               output int latency, output bit trace_ok,
                               output logic [7:0] snap);
    int k;
    int limit;
    limit    = 16 * (sc + 1) + 20;
    latency  = -1;
    trace_ok = 1'b1;
    @(negedge clk);
    setStart(1'b1);
    @(posedge clk);
    #1;
    setStart(1'b0);
    snap = {obs_done, obs_busy, obs_fv, obs_err};
    k = 0;
    while (k < limit) begin
      if (obs_done) begin
        latency = k;
        break;
      end
      if ((int'(obs_dut_in) != k / (sc + 1)) || !obs_busy) trace_ok = 1'b0;
      setStart(k == restart_at);
      @(posedge clk);
      #1;
      k++;
    end
    setStart(1'b0);
  endtask

  task automatic checkSweep(input string tag, input int sc, input int restart_at,
                            input int exp_err, input int exp_fv,
                            input int exp_first, input int exp_pass);
    int         lat;
    bit         tr;
    logic [7:0] snap;
    applyStimulus(sc, restart_at, lat, tr, snap);
    checkOutput({tag, "_start_clears"}, 32'(snap), 32'h40);
    checkOutput({tag, "_latency"}, lat, 16 * (sc + 1));
    checkOutput({tag, "_trace"}, 32'(tr), 1);
    checkOutput({tag, "_err_count"}, obs_err, exp_err);
    checkOutput({tag, "_fail_valid"}, obs_fv, exp_fv);
    checkOutput({tag, "_first_fail"}, obs_ffi, exp_first);
    checkOutput({tag, "_pass"}, obs_pass, exp_pass);
    checkOutput({tag, "_end_state"}, {obs_busy, obs_done, obs_dut_in}, {2'b01, 4'hF});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{"no_fault",   0,  0, 0,  0, 1};
    vecs[1] = '{"z_stuck0",   1,  8, 1,  1, 0};
    vecs[2] = '{"y_stuck1",   2,  9, 1,  0, 0};
    vecs[3] = '{"y_stuck0",   3,  7, 1,  3, 0};
    vecs[4] = '{"invert_all", 4, 16, 1,  0, 0};
    vecs[5] = '{"last_only",  5,  1, 1, 15, 0};

    start_a = 1'b0;
    start_b = 1'b0;
    setFault(0);
    rst_n = 1'b0;
    #12;
    checkOutput("reset_a", {busy_a, done_a, pass_a, err_count_a, fail_valid_a,
                            first_fail_idx_a, dut_in_a}, 0);
    checkOutput("reset_b", {busy_b, done_b, pass_b, err_count_b, fail_valid_b,
                            first_fail_idx_b, dut_in_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven fault scenarios; every start after the first comes from DONE.
    for (int i = 0; i < 6; i++) begin
      setFault(vecs[i].mode);
      checkSweep(vecs[i].name, 2, -1, vecs[i].exp_err, vecs[i].exp_fv,
                 vecs[i].exp_first, vecs[i].exp_pass);
    end

    // Faulty run then a fixed block restarted from DONE.
    setFault(1);
    checkSweep("fix_before", 2, -1, 8, 1, 1, 0);
    setFault(0);
    checkSweep("fix_after", 2, -1, 0, 0, 0, 1);

    // A start re-pulsed mid-sweep must be ignored.
    checkSweep("restart_ignored", 2, 10, 0, 0, 0, 1);

    // Reset in the middle of vector 5 aborts everything at once.
    setFault(1);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int k = 0; k < 200 && dut_in_a != 4'd5; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reach_vec5", dut_in_a, 5);
    checkOutput("pre_reset_errs", {fail_valid_a, err_count_a}, {1'b1, 5'd3});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_abort", {busy_a, done_a, pass_a, err_count_a, fail_valid_a,
                                first_fail_idx_a, dut_in_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", {busy_a, done_a, dut_in_a}, 0);
    setFault(0);
    checkSweep("post_reset", 2, -1, 0, 0, 0, 1);

    // Random fault patterns scored by a simple count-and-find-first model.
    for (int it = 0; it < 8; it++) begin
      int m_err;
      int m_first;
      m_err   = 0;
      m_first = -1;
      for (int v = 0; v < 16; v++) begin
        if ((it % 4 == 0) || ($urandom_range(0, 3) != 0)) flip[v] = 2'b00;
        else flip[v] = 2'($urandom_range(1, 3));
        if (flip[v] != 2'b00) begin
          m_err++;
          if (m_first < 0) m_first = v;
        end
      end
      checkSweep($sformatf("rand%0d", it), 2, -1, m_err, (m_err != 0) ? 1 : 0,
                 (m_first < 0) ? 0 : m_first, (m_err == 0) ? 1 : 0);
    end

    // Short-settle build: every vector held exactly two cycles.
    sel = 1'b1;
    checkSweep("settle1", 1, -1, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
